// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic units: FSM state encoding and default operand width.
package arith_pkg;

    localparam int ARITH_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } arith_state_t;

endpackage

// File: rtl/multiplication_unit_shift_add_step.sv
// One combinational shift-and-add iteration: conditionally accumulate, then shift both operands.
module shift_add_step #(
    parameter int WIDTH = 8
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [2*WIDTH-1:0] mcand,
    input  logic [WIDTH-1:0]   mplier,
    output logic [2*WIDTH-1:0] acc_next,
    output logic [2*WIDTH-1:0] mcand_next,
    output logic [WIDTH-1:0]   mplier_next
);

    // The product of two WIDTH-bit values always fits 2*WIDTH bits, so no carry out is kept.
    assign acc_next    = mplier[0] ? (acc + mcand) : acc;
    assign mcand_next  = mcand << 1;
    assign mplier_next = mplier >> 1;

endmodule

// File: rtl/multiplication_unit.sv
// Sequential unsigned shift-and-add multiplier: WIDTH iterations per operation, zero-operand shortcut.
module multiplication_unit
    import arith_pkg::*;
#(
    parameter int WIDTH = ARITH_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic [2*WIDTH-1:0]   product,
    output logic                 overflow,
    output logic                 busy,
    output logic                 done
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    arith_state_t          state_reg;
    arith_state_t          state_next;
    logic [2*WIDTH-1:0]    acc_reg;
    logic [2*WIDTH-1:0]    mcand_reg;
    logic [WIDTH-1:0]      mplier_reg;
    logic [CNT_W-1:0]      count_reg;
    logic [2*WIDTH-1:0]    product_reg;
    logic                  overflow_reg;

    logic [2*WIDTH-1:0]    acc_next;
    logic [2*WIDTH-1:0]    mcand_next;
    logic [WIDTH-1:0]      mplier_next;
    logic                  zero_operand;
    logic                  last_iter;

    shift_add_step #(.WIDTH(WIDTH)) u_step (
        .acc         (acc_reg),
        .mcand       (mcand_reg),
        .mplier      (mplier_reg),
        .acc_next    (acc_next),
        .mcand_next  (mcand_next),
        .mplier_next (mplier_next)
    );

    assign zero_operand = (multiplicand == '0) || (multiplier == '0);
    assign last_iter    = (count_reg == CNT_W'(1));

    always_comb begin
        state_next = state_reg;
        busy       = (state_reg != IDLE);
        done       = (state_reg == FINISH);
        case (state_reg)
            IDLE:    if (start) state_next = zero_operand ? FINISH : CALC;
            CALC:    if (last_iter) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            acc_reg      <= '0;
            mcand_reg    <= '0;
            mplier_reg   <= '0;
            count_reg    <= '0;
            product_reg  <= '0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        mcand_reg  <= {{WIDTH{1'b0}}, multiplicand};
                        mplier_reg <= multiplier;
                        acc_reg    <= '0;
                        count_reg  <= CNT_W'(WIDTH);
                        // Zero shortcut completes immediately, so the result is published now.
                        if (zero_operand) begin
                            product_reg  <= '0;
                            overflow_reg <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    acc_reg    <= acc_next;
                    mcand_reg  <= mcand_next;
                    mplier_reg <= mplier_next;
                    count_reg  <= count_reg - CNT_W'(1);
                    if (last_iter) begin
                        product_reg  <= acc_next;
                        overflow_reg <= |acc_next[2*WIDTH-1:WIDTH];
                    end
                end
                default: ;
            endcase
        end
    end

    assign product  = product_reg;
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_multiplication_unit.sv
// Scoreboard bench for multiplication_unit: expected results queued at acceptance, checked on done.
module tb_multiplication_unit;

    localparam int W = 8;

    typedef struct packed {
        logic [2*W-1:0] prod;
        logic           ovf;
        logic [31:0]    cyc;
    } exp_t;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           start = 1'b0;
    logic [W-1:0]   multiplicand = '0;
    logic [W-1:0]   multiplier = '0;
    logic [2*W-1:0] product;
    logic           overflow;
    logic           busy;
    logic           done;

    exp_t           sb[$];
    int             tests = 0;
    int             failures = 0;
    logic [31:0]    cyc = 0;
    logic           prev_done = 1'b0;
    logic [2*W-1:0] last_prod = '0;

    multiplication_unit #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .product      (product),
        .overflow     (overflow),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [31:0] n);
        exp_t e;
        logic [31:0] p;
        p      = 32'(a) * 32'(b);
        e.prod = p[2*W-1:0];
        e.ovf  = (p >= 32'(1 << W));
        e.cyc  = (a == 0 || b == 0) ? n : n + W;
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest queued expectation, in value and timing.
    always @(negedge clk) begin
        if (done && !reset) begin
            check("done_single", 32'(prev_done), 0);
            if (sb.size() == 0) begin
                check("spurious_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("product", 32'(product), 32'(e.prod));
                check("overflow", 32'(overflow), 32'(e.ovf));
                check("done_cycle", cyc, e.cyc);
                last_prod = e.prod;
                $display("[TB] cycle %0d done product=0x%04h overflow=%0b", cyc, product, overflow);
            end
        end
        prev_done = done;
    end

    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start        = 1'b1;
        multiplicand = a;
        multiplier   = b;
        @(posedge clk);
        #1;
        sb.push_back(model(a, b, cyc));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            check("timeout_pending", 32'(sb.size()), 0);
            sb.delete();
        end
        @(negedge clk);
        check("busy_after", 32'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_product", 32'(product), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);

        launch(8'd13, 8'd11);
        wait_idle(30);
        launch(8'd255, 8'd255);
        wait_idle(30);
        launch(8'd0, 8'd200);
        wait_idle(30);
        launch(8'd200, 8'd0);
        wait_idle(30);

        // Start and operand changes during CALC must not disturb the running operation.
        launch(8'd7, 8'd9);
        @(negedge clk);
        check("prod_hold_busy", 32'(product), 32'(last_prod));
        start        = 1'b1;
        multiplicand = 8'd200;
        multiplier   = 8'd200;
        repeat (3) @(negedge clk);
        start = 1'b0;
        wait_idle(30);
        repeat (12) @(negedge clk);
        check("prod_after_ignore", 32'(product), 32'h003F);

        // Reset at edge N+4 aborts with no done and clears the result.
        @(negedge clk);
        start        = 1'b1;
        multiplicand = 8'd100;
        multiplier   = 8'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_product", 32'(product), 0);
        check("abort_overflow", 32'(overflow), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        repeat (12) @(negedge clk);
        check("abort_idle_busy", 32'(busy), 0);
        launch(8'd16, 8'd16);
        wait_idle(30);

        // Start held high: back-to-back operations every WIDTH+2 cycles.
        begin
            logic [31:0] n;
            exp_t e;
            @(negedge clk);
            start        = 1'b1;
            multiplicand = 8'd2;
            multiplier   = 8'd3;
            @(posedge clk);
            #1;
            n = cyc;
            for (int k = 0; k < 3; k++) begin
                e = model(8'd2, 8'd3, n + 32'(k * (W + 2)));
                sb.push_back(e);
            end
            for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
            start = 1'b0;
            wait_idle(30);
        end

        for (int k = 0; k < 6; k++) begin
            launch(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
            wait_idle(30);
        end
        launch(8'd1, 8'd255);
        wait_idle(30);
        launch(8'd16, 8'd15);
        wait_idle(30);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
